// File: rtl/light_monitor.sv
// Checks the traffic-light controller outputs for illegal encodings, conflicts, bad sequencing and
// timing faults; latches the first fault and drives flashing red to the lamps until cleared.
module light_monitor #(
    parameter int unsigned WD_LIMIT   = 1023,
    parameter int unsigned FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] highway_light,
    input  logic [2:0] country_light,
    input  logic [6:0] Timeout,
    input  logic [3:0] timeout,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] safe_h,
    output logic [2:0] safe_c,
    output logic [7:0] hw_cycles
);

    localparam int unsigned FlashW = ($clog2(2 * FLASH_HALF) > 8) ? $clog2(2 * FLASH_HALF) : 8;

    localparam logic [2:0] Red = 3'b100;
    localparam logic [2:0] Yel = 3'b010;
    localparam logic [2:0] Grn = 3'b001;
    localparam logic [2:0] Off = 3'b000;

    localparam logic [9:0]        WdLimit   = WD_LIMIT[9:0];
    localparam logic [FlashW-1:0] FlashHalf = FlashW'(FLASH_HALF);
    localparam logic [FlashW-1:0] FlashLast = FlashW'(2 * FLASH_HALF - 1);

    logic [2:0]        prev_h_q, prev_c_q;
    logic              prev_valid_q;
    logic [3:0]        yel_h_q, yel_c_q, yel_h_d, yel_c_d;
    logic [6:0]        hg_q, hg_d;
    logic [9:0]        wd_q, wd_d;
    logic [FlashW-1:0] flash_q;
    logic              fault_q;
    logic [2:0]        code_q, code_d;
    logic [2:0]        safe_h_q, safe_c_q;
    logic [7:0]        hw_q;

    logic enc_bad, conflict, seq_bad, yel_bad, wd_bad, mg_bad, same, hw_inc;

    function automatic logic is_legal(input logic [2:0] l);
        return (l == Red) || (l == Yel) || (l == Grn);
    endfunction

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] n);
        return (p == n) || (p == Grn && n == Yel) || (p == Yel && n == Red) ||
               (p == Red && n == Grn);
    endfunction

    always_comb begin
        enc_bad  = !is_legal(highway_light) || !is_legal(country_light);
        conflict = (highway_light != Red) && (country_light != Red);
        seq_bad  = prev_valid_q &&
                   (!step_ok(prev_h_q, highway_light) || !step_ok(prev_c_q, country_light));

        yel_h_d = 4'd0;
        if (highway_light == Yel) yel_h_d = (yel_h_q == 4'hf) ? 4'hf : yel_h_q + 4'd1;
        yel_c_d = 4'd0;
        if (country_light == Yel) yel_c_d = (yel_c_q == 4'hf) ? 4'hf : yel_c_q + 4'd1;
        // Compare the unsaturated run length so timeout=15 still trips on the 16th sample
        yel_bad = (timeout != 4'd0) &&
                  (((highway_light == Yel) && ({1'b0, yel_h_q} + 5'd1 > {1'b0, timeout})) ||
                   ((country_light == Yel) && ({1'b0, yel_c_q} + 5'd1 > {1'b0, timeout})));

        same   = prev_valid_q && (highway_light == prev_h_q) && (country_light == prev_c_q);
        wd_d   = 10'd0;
        if (same) wd_d = (wd_q >= WdLimit) ? WdLimit : wd_q + 10'd1;
        wd_bad = same && ({1'b0, wd_q} + 11'd1 >= {1'b0, WdLimit});

        hg_d = 7'd0;
        if (highway_light == Grn) hg_d = (hg_q == 7'h7f) ? 7'h7f : hg_q + 7'd1;
        mg_bad = prev_valid_q && (Timeout != 7'd0) && (prev_h_q == Grn) &&
                 (highway_light == Yel) && (hg_q < Timeout);

        hw_inc = prev_valid_q && (prev_h_q == Red) && (highway_light == Grn);

        code_d = 3'd0;
        if (enc_bad)       code_d = 3'd1;
        else if (conflict) code_d = 3'd2;
        else if (seq_bad)  code_d = 3'd3;
        else if (yel_bad)  code_d = 3'd4;
        else if (wd_bad)   code_d = 3'd5;
        else if (mg_bad)   code_d = 3'd6;
    end

    always_ff @(posedge clk) begin
        if (!reset || fault_clr) begin
            prev_h_q     <= Red;
            prev_c_q     <= Red;
            prev_valid_q <= 1'b0;
            yel_h_q      <= 4'd0;
            yel_c_q      <= 4'd0;
            hg_q         <= 7'd0;
            wd_q         <= 10'd0;
            flash_q      <= '0;
            fault_q      <= 1'b0;
            code_q       <= 3'd0;
            safe_h_q     <= Red;
            safe_c_q     <= Red;
        end else begin
            prev_h_q     <= highway_light;
            prev_c_q     <= country_light;
            prev_valid_q <= 1'b1;
            yel_h_q      <= yel_h_d;
            yel_c_q      <= yel_c_d;
            hg_q         <= hg_d;
            wd_q         <= wd_d;
            if (!fault_q && code_d != 3'd0) begin
                fault_q <= 1'b1;
                code_q  <= code_d;
            end
            // Flash begins one edge after the fault latches, red half first
            if (fault_q) begin
                safe_h_q <= (flash_q < FlashHalf) ? Red : Off;
                safe_c_q <= (flash_q < FlashHalf) ? Red : Off;
                flash_q  <= (flash_q == FlashLast) ? '0 : flash_q + 1'b1;
            end else begin
                safe_h_q <= highway_light;
                safe_c_q <= country_light;
            end
        end

        if (!reset) begin
            hw_q <= 8'd0;
        end else if (!fault_clr && hw_inc) begin
            hw_q <= hw_q + 8'd1;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign safe_h     = safe_h_q;
    assign safe_c     = safe_c_q;
    assign hw_cycles  = hw_q;

endmodule

// File: tb/tb_light_monitor.sv
// Directed scoreboard bench for light_monitor: each driven cycle queues its expected outputs,
// and a monitor pops and checks them after every rising edge.
module tb_light_monitor;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] Off = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] highway_light, country_light;
    logic [6:0] Timeout;
    logic [3:0] timeout;
    logic       fault_clr;
    logic       fault;
    logic [2:0] fault_code, safe_h, safe_c;
    logic [7:0] hw_cycles;

    always #5 clk = ~clk;

    light_monitor #(
        .WD_LIMIT  (1023),
        .FLASH_HALF(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .highway_light(highway_light),
        .country_light(country_light),
        .Timeout      (Timeout),
        .timeout      (timeout),
        .fault_clr    (fault_clr),
        .fault        (fault),
        .fault_code   (fault_code),
        .safe_h       (safe_h),
        .safe_c       (safe_c),
        .hw_cycles    (hw_cycles)
    );

    typedef struct packed {
        logic       fault;
        logic [2:0] code;
        logic [2:0] sh;
        logic [2:0] sc;
        logic [7:0] hw;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Expected state for the cycles that follow; e_pass means lamps echo this cycle's inputs
    logic       e_fault;
    logic [2:0] e_code;
    logic       e_pass;
    logic [2:0] e_sh, e_sc;
    logic [7:0] e_hw;

    task automatic expect_state(input logic f, input logic [2:0] code, input logic pass,
                                input logic [2:0] s, input logic [7:0] hw);
        e_fault = f;
        e_code  = code;
        e_pass  = pass;
        e_sh    = s;
        e_sc    = s;
        e_hw    = hw;
    endtask

    task automatic cyc(input logic [2:0] h, input logic [2:0] c);
        exp_t e;
        highway_light = h;
        country_light = c;
        e.fault = e_fault;
        e.code  = e_code;
        e.sh    = e_pass ? h : e_sh;
        e.sc    = e_pass ? c : e_sc;
        e.hw    = e_hw;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic cycn(input logic [2:0] h, input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) cyc(h, c);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, vectors, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                chk("fault", {7'd0, fault}, {7'd0, e.fault});
                chk("fault_code", {5'd0, fault_code}, {5'd0, e.code});
                chk("safe_h", {5'd0, safe_h}, {5'd0, e.sh});
                chk("safe_c", {5'd0, safe_c}, {5'd0, e.sc});
                chk("hw_cycles", hw_cycles, e.hw);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0; fault_clr = 1'b0; Timeout = 7'd10; timeout = 4'd4;

        // Reset, then a full legal cycle
        expect_state(0, 0, 0, R, 0);
        cycn(R, R, 2);
        reset = 1'b1;
        expect_state(0, 0, 1, R, 0);
        cycn(G, R, 20); cycn(Y, R, 3); cyc(R, R);
        cycn(R, G, 3);  cycn(R, Y, 3); cyc(R, R);
        e_hw = 8'd1;
        cycn(G, R, 2);

        // Illegal encoding, then the flash pattern
        e_fault = 1; e_code = 3'd1;
        cyc(3'b011, R);
        e_pass = 0; e_sh = R;   e_sc = R;   cycn(G, R, 8);
        e_sh = Off; e_sc = Off; cycn(G, R, 8);
        e_sh = R;   e_sc = R;   cycn(G, R, 8);
        fault_clr = 1'b1; expect_state(0, 0, 0, R, 1); cyc(G, R); fault_clr = 1'b0;

        // Conflict outranks the otherwise-legal country R->G step
        expect_state(0, 0, 1, R, 1);
        cyc(R, R);
        e_fault = 1; e_code = 3'd2; e_hw = 8'd2;
        cyc(G, G);
        e_pass = 0; e_sh = R; e_sc = R;
        cyc(R, R);
        fault_clr = 1'b1; expect_state(0, 0, 0, R, 2); cyc(R, R); fault_clr = 1'b0;

        // Sequence fault G->R; later conflict keeps code 3
        expect_state(0, 0, 1, R, 2);
        cycn(G, R, 2);
        e_fault = 1; e_code = 3'd3;
        cyc(R, R);
        e_pass = 0; e_sh = R; e_sc = R; e_hw = 8'd3;
        cyc(G, G);
        fault_clr = 1'b1; expect_state(0, 0, 0, R, 3); cyc(R, R); fault_clr = 1'b0;
        expect_state(0, 0, 1, R, 3);
        cycn(R, G, 2);

        // Yellow too long with timeout=3
        Timeout = 7'd0; timeout = 4'd3;
        cyc(R, Y); cyc(R, R);
        e_hw = 8'd4;
        cyc(G, R); cycn(Y, R, 3);
        e_fault = 1; e_code = 3'd4;
        cyc(Y, R);
        e_pass = 0; e_sh = R; e_sc = R;
        cyc(R, R);
        fault_clr = 1'b1; expect_state(0, 0, 0, R, 4); cyc(R, R); fault_clr = 1'b0;

        // Same long yellow with the check disabled
        timeout = 4'd0;
        expect_state(0, 0, 1, R, 4);
        cyc(G, R); cycn(Y, R, 6); cyc(R, R);

        // Highway green too short
        Timeout = 7'd10; timeout = 4'd4;
        e_hw = 8'd5;
        cycn(G, R, 5);
        e_fault = 1; e_code = 3'd6;
        cyc(Y, R);
        e_pass = 0; e_sh = R; e_sc = R;
        cyc(Y, R);
        fault_clr = 1'b1; expect_state(0, 0, 0, R, 5); cyc(R, R); fault_clr = 1'b0;

        // Watchdog: 1023 unchanged samples after the change into (R,G)
        expect_state(0, 0, 1, R, 5);
        cyc(R, R);
        cycn(R, G, 1023);
        e_fault = 1; e_code = 3'd5;
        cyc(R, G);
        e_pass = 0; e_sh = R;   e_sc = R;   cycn(R, G, 8);
        e_sh = Off; e_sc = Off; cycn(R, G, 2);

        // Reset in the dark half of the flash
        reset = 1'b0;
        expect_state(0, 0, 0, R, 0);
        cyc(R, G);
        reset = 1'b1;
        expect_state(0, 0, 1, R, 0);
        cyc(R, G);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
Name: light_monitor

Overview:
- Conflict/sequence monitor sitting downstream of the traffic-light controller. It consumes `highway_light` and `country_light` and acts as their reader/checker.
- Validates encoding, mutual exclusion, phase order, yellow duration, minimum highway green and liveness.
- On the first violation it latches a fault code and drives failsafe flashing-red outputs to the lamp drivers. With no fault it passes the lights through, registered.
- Light encoding: bit2 = red, bit1 = yellow, bit0 = green. Legal values are 3'b100, 3'b010 and 3'b001 only.

Parameters:
- WD_LIMIT, 1023: maximum consecutive cycles with both lights unchanged before a watchdog fault; 10-bit range.
- FLASH_HALF, 8: cycles per half-period of the failsafe red flash; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- highway_light  input  3  highway light from the controller.
- country_light  input  3  country light from the controller.
- Timeout  input  7  minimum highway-green cycles; 0 disables the check.
- timeout  input  4  maximum yellow cycles per light; 0 disables the check.
- fault_clr  input  1  synchronous clear of a latched fault.
- fault  output  1  sticky fault flag.
- fault_code  output  3  first fault detected; 0 means none.
- safe_h  output  3  highway lamp drive.
- safe_c  output  3  country lamp drive.
- hw_cycles  output  8  count of completed highway R→G transitions; wraps at 255→0.

Behaviour:
- Clock, reset and clear:
  - Single clock domain. Reset is synchronous and active-low: `reset`=0 at a rising edge of `clk` resets the block.
  - Reset values: `fault`=0, `fault_code`=0, `safe_h`=`safe_c`=3'b100, `hw_cycles`=0. All internal counters are 0 and `prev_valid`=0.
  - Reset has priority over everything, including mid-fault and mid-flash.
  - `fault_clr`=1 has the same effect as reset except that `hw_cycles` is kept. `fault_clr` is ignored while `reset`=0.
- Sampling:
  - Both inputs are sampled every edge into `prev_h`/`prev_c`, and `prev_valid` is then set to 1.
  - All checks compare the current inputs against `prev_*`. Transition-based checks (codes 3 and 6) are skipped while `prev_valid`=0.
- Fault timing:
  - `fault`/`fault_code` are set on the same edge that samples the offending value.
  - `safe_*` switches to flash on the next edge.
- Fault codes, priority lowest number first. Only the first fault latches; later faults do not change the code.
  - 1 ENC: either light not one-hot. When this fires, codes 2–6 are not evaluated that cycle.
  - 2 CONFLICT: both lights ≠ 3'b100 simultaneously.
  - 3 SEQ: per light, legal steps are hold, G→Y, Y→R and R→G. Any other change is a fault.
  - 4 YEL_LONG: per-light yellow run counter (4-bit, saturating at 15). It counts 1 on the first yellow sample and increments while yellow holds. Fault when the count would reach `timeout`+1 (`timeout`≠0). The counter resets on any non-yellow sample.
  - 5 WATCHDOG: counter of consecutive samples where both lights equal `prev_*`. Fault when it reaches WD_LIMIT. The counter resets on any change.
  - 6 MIN_GREEN: highway green run counter (7-bit, saturating). Fault if highway goes G→Y with count < `Timeout` (`Timeout`≠0).
- `hw_cycles`:
  - Increments on a highway R→G step with `prev_valid`=1.
  - Counts even after a fault.
- Lamp outputs:
  - No fault: `safe_h`/`safe_c` = sampled inputs (1-cycle registered pass-through).
  - Fault: both outputs show 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating. The flash starts red-on on the first edge after `fault` rises.
- Counter sizing: 10-bit watchdog, 4-bit yellow, 7-bit green, and a flash counter of at least 8 bits. No counter may wrap silently except `hw_cycles`.

Test Plan:
- Reset low 2 cycles, then legal cycle (H G×20 → Y×3 → R, C R→G→Y×3→R) with `Timeout`=10, `timeout`=4 → `fault`=0, `safe_*` track the inputs with 1-cycle delay, `hw_cycles`=1 after H returns to G.
- Drive `highway_light`=3'b011 for 1 cycle → `fault`=1, `fault_code`=1 on that edge; next edge `safe_h`=`safe_c`=3'b100; after 8 cycles both go 3'b000, then 3'b100 again after another 8.
- H=3'b001 and C=3'b001 together → `fault_code`=2 (not 3, even if C's step R→G is otherwise legal).
- Highway G→R directly → `fault_code`=3. A subsequent conflict does not change the code. `fault_clr` pulse → `fault`=0 and `safe_*` back to pass-through.
- `timeout`=3, highway yellow held 4 cycles → `fault_code`=4 on the 4th yellow sample. Repeat with `timeout`=0 → no fault.
- `Timeout`=10, highway G for 5 cycles then Y → `fault_code`=6. Separately, hold all lights 1023 cycles → `fault_code`=5. Assert `reset`=0 mid-flash → all outputs return to reset values on that edge.
